// File: rtl/digit_bank.sv
// Eight-entry bank of 4-bit digit registers feeding the display multiplexer.
// Supports random-access writes, shift-in entry and pointer-based sequential writes.
module digit_bank #(
  parameter logic [3:0] RESET_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       push,
  input  logic       seq_wr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [3:0] d7,
  output logic [2:0] ptr,
  output logic       full,
  output logic       ack
);

  // Strobes are level-sampled with no backpressure: every edge that sees a
  // strobe executes one command, and ack is high the cycle after each such edge.
  // Lower-priority strobes in the same cycle are dropped.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_WRITE,
    CMD_PUSH,
    CMD_SEQ
  } cmd_e;

  cmd_e       cmd;
  logic [3:0] dig_q [8];
  logic [3:0] dig_d [8];
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       full_q, full_d;
  logic       ack_q, ack_d;

  always_comb begin
    cmd = CMD_NONE;
    if (clr)         cmd = CMD_CLR;
    else if (wr_en)  cmd = CMD_WRITE;
    else if (push)   cmd = CMD_PUSH;
    else if (seq_wr) cmd = CMD_SEQ;
  end

  assign cnt_inc = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;

  always_comb begin
    dig_d = dig_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ack_d = 1'b0;
    unique case (cmd)
      CMD_CLR: begin
        for (int i = 0; i < 8; i++) dig_d[i] = RESET_VAL;
        ptr_d = 3'd0;
        cnt_d = 4'd0;
        ack_d = 1'b1;
      end
      CMD_WRITE: begin
        dig_d[wr_addr] = wr_data;
        ack_d          = 1'b1;
      end
      CMD_PUSH: begin
        for (int i = 7; i > 0; i--) dig_d[i] = dig_q[i-1];
        dig_d[0] = wr_data;
        cnt_d    = cnt_inc;
        ack_d    = 1'b1;
      end
      CMD_SEQ: begin
        dig_d[ptr_q] = wr_data;
        ptr_d        = ptr_q + 3'd1;
        cnt_d        = cnt_inc;
        ack_d        = 1'b1;
      end
      default: ;
    endcase
    full_d = (cnt_d == 4'd8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dig_q[i] <= RESET_VAL;
      ptr_q  <= 3'd0;
      cnt_q  <= 4'd0;
      full_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) dig_q[i] <= dig_d[i];
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ack_q  <= ack_d;
    end
  end

  assign d0   = dig_q[0];
  assign d1   = dig_q[1];
  assign d2   = dig_q[2];
  assign d3   = dig_q[3];
  assign d4   = dig_q[4];
  assign d5   = dig_q[5];
  assign d6   = dig_q[6];
  assign d7   = dig_q[7];
  assign ptr  = ptr_q;
  assign full = full_q;
  assign ack  = ack_q;

endmodule

// File: tb/tb_digit_bank.sv
// Directed bench for digit_bank: hand-computed bank images {d7..d0}, ptr, full, ack.
module tb_digit_bank;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       push;
  logic       seq_wr;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [2:0] ptr;
  logic       full;
  logic       ack;

  int checks = 0;
  int errors = 0;

  digit_bank #(.RESET_VAL(4'hF)) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .push    (push),
    .seq_wr  (seq_wr),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .d4      (d4),
    .d5      (d5),
    .d6      (d6),
    .d7      (d7),
    .ptr     (ptr),
    .full    (full),
    .ack     (ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag, input logic [31:0] bank, input logic [2:0] eptr,
                            input logic efull, input logic eack);
    check({tag, " bank"}, {d7, d6, d5, d4, d3, d2, d1, d0}, bank);
    check({tag, " ptr"},  {29'd0, ptr}, {29'd0, eptr});
    check({tag, " full"}, {31'd0, full}, {31'd0, efull});
    check({tag, " ack"},  {31'd0, ack}, {31'd0, eack});
  endtask

  // driver: advance one edge, settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; push = 0; seq_wr = 0;
  endtask

  initial begin
    reset = 1; idle(); wr_addr = 0; wr_data = 0;
    step(); step();
    reset = 0;
    check_bank("reset", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);

    clr = 1; step(); idle();
    check_bank("clr", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1);
    step();
    check_bank("clr idle", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);

    wr_en = 1; wr_addr = 3'd5; wr_data = 4'hA; step(); idle();
    check_bank("wr5", 32'hFFAF_FFFF, 3'd0, 1'b0, 1'b1);
    step();
    check_bank("wr5 idle", 32'hFFAF_FFFF, 3'd0, 1'b0, 1'b0);

    push = 1;
    wr_data = 4'h1; step(); check_bank("push1", 32'hFAFF_FFF1, 3'd0, 1'b0, 1'b1);
    wr_data = 4'h2; step(); check_bank("push2", 32'hAFFF_FF12, 3'd0, 1'b0, 1'b1);
    wr_data = 4'h3; step(); check_bank("push3", 32'hFFFF_F123, 3'd0, 1'b0, 1'b1);
    idle();

    clr = 1; push = 1; step(); idle();
    check_bank("clr over push", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1);

    push = 1;
    for (int i = 1; i <= 9; i++) begin
      wr_data = 4'(i);
      step();
      if (i == 7) check_bank("push7", 32'hF123_4567, 3'd0, 1'b0, 1'b1);
      if (i == 8) check_bank("push8", 32'h1234_5678, 3'd0, 1'b1, 1'b1);
      if (i == 9) check_bank("push9", 32'h2345_6789, 3'd0, 1'b1, 1'b1);
    end
    idle();

    clr = 1; step(); idle();
    seq_wr = 1;
    for (int i = 0; i <= 8; i++) begin
      wr_data = 4'(i);
      step();
      check("seq ack", {31'd0, ack}, 32'd1);
      if (i == 6) check_bank("seq7", 32'hF654_3210, 3'd7, 1'b0, 1'b1);
      if (i == 7) check_bank("seq8", 32'h7654_3210, 3'd0, 1'b1, 1'b1);
      if (i == 8) check_bank("seq9", 32'h7654_3218, 3'd1, 1'b1, 1'b1);
    end
    idle();

    wr_en = 1; push = 1; seq_wr = 1; wr_addr = 3'd3; wr_data = 4'h6; step(); idle();
    check_bank("priority", 32'h7654_6218, 3'd1, 1'b1, 1'b1);
    step();
    check_bank("priority idle", 32'h7654_6218, 3'd1, 1'b1, 1'b0);

    reset = 1; clr = 1; step(); reset = 0; idle();
    check_bank("reset+clr", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);

    seq_wr = 1; wr_data = 4'hB;
    step(); step(); step();
    check_bank("burst3", 32'hFFFF_FBBB, 3'd3, 1'b0, 1'b1);
    reset = 1; step(); reset = 0;
    check_bank("burst reset", 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
    wr_data = 4'hC; step(); idle();
    check_bank("burst resume", 32'hFFFF_FFFC, 3'd1, 1'b0, 1'b1);
    step();
    check_bank("burst idle", 32'hFFFF_FFFC, 3'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
